// File: rtl/alimentador_anillo.sv
`default_nettype none
// ============================================================================
//  Module      : alimentador_anillo
//  Description : Feeder for a 4-lane systolic ring. Holds a 4x4 coefficient
//                store, streams four diagonally skewed steps onto the lanes,
//                waits LAT cycles for the ring, then captures the results.
//                Optional macro ALIMENTADOR_ZEROPAD_EN: lanes read 0 whenever
//                a_valid is low (otherwise they hold the last fed step).
//  Revision    : 1.0 - initial release
// ============================================================================
module alimentador_anillo #(
    parameter int WIDTH = 16,
    parameter int LAT   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] a2,
    output logic [WIDTH-1:0] a3,
    output logic [WIDTH-1:0] a4,
    output logic             a_valid,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] y2,
    input  logic [WIDTH-1:0] y3,
    input  logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last value of the wait counter before the ring results are valid
    localparam logic [3:0] C_WAIT_LAST = 4'(LAT - 1);

    state_t           state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [WIDTH-1:0] coef_q [16];
    logic [WIDTH-1:0] coef_d [16];
    logic [WIDTH-1:0] a_q [4];
    logic [WIDTH-1:0] a_d [4];
    logic [WIDTH-1:0] r_q [4];
    logic [WIDTH-1:0] r_d [4];
    logic             a_valid_q, a_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       k_sel;
    logic             load_step;

    // Next-state, store update and lane selection for the feed sequencer
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        wcnt_d    = wcnt_q;
        coef_d    = coef_q;
        a_d       = a_q;
        r_d       = r_q;
        a_valid_d = a_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        k_sel     = 2'd0;
        load_step = 1'b0;

        // The store is only writable while idle; step 0 reads through coef_d
        // so a write on the start edge is already visible on the lanes.
        if (state_q == IDLE && wr_en) begin
            coef_d[wr_addr] = wr_data;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FEED;
                    k_d       = 2'd0;
                    k_sel     = 2'd0;
                    load_step = 1'b1;
                    a_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            FEED: begin
                if (k_q == 2'd3) begin
                    state_d   = WAIT;
                    wcnt_d    = 4'd0;
                    a_valid_d = 1'b0;
`ifdef ALIMENTADOR_ZEROPAD_EN
                    a_d       = '{default: '0};
`endif
                end else begin
                    k_d       = k_q + 2'd1;
                    k_sel     = k_q + 2'd1;
                    load_step = 1'b1;
                end
            end
            WAIT: begin
                if (wcnt_q == C_WAIT_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    r_d[0]  = y1;
                    r_d[1]  = y2;
                    r_d[2]  = y3;
                    r_d[3]  = y4;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                k_d     = 2'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Lane i takes row i, column (k+i) mod 4: the diagonal skew of the ring
        if (load_step) begin
            for (int i = 0; i < 4; i++) begin
                a_d[i] = coef_d[{2'(i), k_sel + 2'(i)}];
            end
        end
    end

    // State and output registers, cleared asynchronously by reset low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            k_q       <= 2'd0;
            wcnt_q    <= 4'd0;
            coef_q    <= '{default: '0};
            a_q       <= '{default: '0};
            r_q       <= '{default: '0};
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            wcnt_q    <= wcnt_d;
            coef_q    <= coef_d;
            a_q       <= a_d;
            r_q       <= r_d;
            a_valid_q <= a_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign a1      = a_q[0];
    assign a2      = a_q[1];
    assign a3      = a_q[2];
    assign a4      = a_q[3];
    assign r1      = r_q[0];
    assign r2      = r_q[1];
    assign r3      = r_q[2];
    assign r4      = r_q[3];
    assign a_valid = a_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alimentador_anillo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alimentador_anillo
//  Description : Self-checking bench for alimentador_anillo. Expected lane
//                steps and captured results are queued before each pass and
//                compared as the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alimentador_anillo;

    localparam int W   = 16;
    localparam int LAT = 4;
    localparam int C_DONE_CYC = 4 + LAT + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         wr_en = 1'b0;
    logic [3:0]   wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic         start = 1'b0;
    logic [W-1:0] a1, a2, a3, a4;
    logic         a_valid;
    logic [W-1:0] y1 = '0, y2 = '0, y3 = '0, y4 = '0;
    logic [W-1:0] r1, r2, r3, r4;
    logic         busy, done;

    int errors = 0;
    int checks = 0;

    logic [4*W-1:0] exp_a[$];
    logic [4*W-1:0] exp_r[$];
    logic [W-1:0]   model[16];

    alimentador_anillo #(.WIDTH(W), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a_valid(a_valid),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4), .r1(r1), .r2(r2), .r3(r3), .r4(r4),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected lane vector for step k from the bench's own copy of the store
    function automatic logic [4*W-1:0] step_vec(input int k);
        return {model[(k) % 4], model[4 + (k + 1) % 4],
                model[8 + (k + 2) % 4], model[12 + (k + 3) % 4]};
    endfunction

    task automatic load(input logic [3:0] addr, input logic [W-1:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        model[addr] = data;
    endtask

    // One pass: start (optionally with a write), extra start pulses per mask,
    // optional write at cycle wr_cyc, optional ramping ring results.
    task automatic run_pass(input int max_cyc, input logic [31:0] start_mask, input int wr_cyc,
                            input bit with_wr, input logic [3:0] waddr, input logic [W-1:0] wdata,
                            input bit ramp, output int ndone, output int nvalid);
        logic [4*W-1:0] e;
        ndone = 0; nvalid = 0;
        start = 1'b1; wr_en = with_wr; wr_addr = waddr; wr_data = wdata;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            start = start_mask[c];
            wr_en = (c == wr_cyc);
            if (ramp) begin
                y1 = W'(c * 256 + 1); y2 = W'(c * 256 + 2);
                y3 = W'(c * 256 + 3); y4 = W'(c * 256 + 4);
            end
            checks++;
            if (a_valid !== (c >= 1 && c <= 4)) begin
                errors++;
                $display("FAIL a_valid_cycle%0d: got %b expected %b", c, a_valid, (c >= 1 && c <= 4));
            end
            checks++;
            if (busy !== (c <= C_DONE_CYC)) begin
                errors++;
                $display("FAIL busy_cycle%0d: got %b expected %b", c, busy, (c <= C_DONE_CYC));
            end
            checks++;
            if (done !== (c == C_DONE_CYC)) begin
                errors++;
                $display("FAIL done_cycle%0d: got %b expected %b", c, done, (c == C_DONE_CYC));
            end
            if (a_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL lanes_extra: got %h expected none", {a1, a2, a3, a4});
                end else begin
                    e = exp_a.pop_front();
                    if ({a1, a2, a3, a4} !== e) begin
                        errors++;
                        $display("FAIL lanes_step: got %h expected %h", {a1, a2, a3, a4}, e);
                    end
                end
            end
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (exp_r.size() == 0) begin
                    errors++;
                    $display("FAIL result_extra: got %h expected none", {r1, r2, r3, r4});
                end else begin
                    e = exp_r.pop_front();
                    if ({r1, r2, r3, r4} !== e) begin
                        errors++;
                        $display("FAIL result: got %h expected %h", {r1, r2, r3, r4}, e);
                    end
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0; wr_en = 1'b0;
        checks++;
        if (ndone != 1 || nvalid != 4 || exp_a.size() != 0 || exp_r.size() != 0) begin
            errors++;
            $display("FAIL pass_counts: got done=%0d valid=%0d left_a=%0d left_r=%0d expected 1 4 0 0",
                     ndone, nvalid, exp_a.size(), exp_r.size());
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({a1, a2, a3, a4} !== '0) begin
            errors++; $display("FAIL reset_lanes: got %h expected 0", {a1, a2, a3, a4});
        end
        checks++;
        if ({r1, r2, r3, r4} !== '0) begin
            errors++; $display("FAIL reset_results: got %h expected 0", {r1, r2, r3, r4});
        end
        checks++;
        if ({a_valid, busy, done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {a_valid, busy, done});
        end
        for (int i = 0; i < 16; i++) model[i] = '0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_feed();
        int nd, nv;
        logic [4*W-1:0] idle_exp;
        for (int i = 0; i < 16; i++) load(4'(i), W'(i + 1));
        exp_a.push_back({16'h0001, 16'h0006, 16'h000B, 16'h0010});
        exp_a.push_back({16'h0002, 16'h0007, 16'h000C, 16'h000D});
        exp_a.push_back({16'h0003, 16'h0008, 16'h0009, 16'h000E});
        exp_a.push_back({16'h0004, 16'h0005, 16'h000A, 16'h000F});
        y1 = 16'h001E; y2 = 16'h0046; y3 = 16'h006E; y4 = 16'h0096;
        exp_r.push_back({16'h001E, 16'h0046, 16'h006E, 16'h0096});
        run_pass(12, 32'h0, -1, 1'b0, 4'd0, '0, 1'b0, nd, nv);
`ifdef ALIMENTADOR_ZEROPAD_EN
        idle_exp = '0;
`else
        idle_exp = {16'h0004, 16'h0005, 16'h000A, 16'h000F};
`endif
        checks++;
        if ({a1, a2, a3, a4} !== idle_exp) begin
            errors++; $display("FAIL idle_lanes: got %h expected %h", {a1, a2, a3, a4}, idle_exp);
        end
    endtask

    task automatic test_capture_timing();
        int nd, nv;
        for (int k = 0; k < 4; k++) exp_a.push_back(step_vec(k));
        exp_r.push_back({16'h0801, 16'h0802, 16'h0803, 16'h0804});
        run_pass(11, 32'h0, -1, 1'b0, 4'd0, '0, 1'b1, nd, nv);
    endtask

    task automatic test_write_ignored();
        int nd, nv;
        y1 = 16'h1111; y2 = 16'h2222; y3 = 16'h3333; y4 = 16'h4444;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) exp_a.push_back(step_vec(k));
            exp_r.push_back({y1, y2, y3, y4});
            run_pass(11, 32'h0, (p == 0) ? 6 : -1, 1'b0, 4'd0, 16'hFFFF, 1'b0, nd, nv);
        end
    endtask

    task automatic test_back_to_back();
        int nd, nv;
        y1 = 16'hA5A5; y2 = 16'h5A5A; y3 = 16'h0F0F; y4 = 16'hF0F0;
        for (int k = 0; k < 4; k++) exp_a.push_back(step_vec(k));
        exp_r.push_back({y1, y2, y3, y4});
        run_pass(14, (32'h1 << 2) | (32'h1 << 6) | (32'h1 << 9), -1, 1'b0, 4'd0, '0, 1'b0, nd, nv);
    endtask

    task automatic test_reset_midpass();
        int nd, nv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({a_valid, busy} !== 2'b11 || {a1, a2, a3, a4} !== step_vec(2)) begin
            errors++;
            $display("FAIL step2_before_reset: got %b %h expected 11 %h", {a_valid, busy}, {a1, a2, a3, a4}, step_vec(2));
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({a_valid, busy, done} !== 3'b000) begin
            errors++; $display("FAIL midreset_flags: got %b expected 000", {a_valid, busy, done});
        end
        checks++;
        if ({r1, r2, r3, r4} !== '0 || {a1, a2, a3, a4} !== '0) begin
            errors++; $display("FAIL midreset_data: got %h %h expected 0 0", {r1, r2, r3, r4}, {a1, a2, a3, a4});
        end
        #2;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        model[5] = 16'h0077;
        y1 = 16'h0101; y2 = 16'h0202; y3 = 16'h0303; y4 = 16'h0404;
        for (int k = 0; k < 4; k++) exp_a.push_back(step_vec(k));
        exp_r.push_back({y1, y2, y3, y4});
        run_pass(11, 32'h0, -1, 1'b1, 4'd5, 16'h0077, 1'b0, nd, nv);
    endtask

    initial begin
        test_reset();
        test_feed();
        test_capture_timing();
        test_write_ignored();
        test_back_to_back();
        test_reset_midpass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
